// File: rtl/conv_job_scheduler.sv
// Convolution job scheduler: walks output rows (inner) and channels (outer) and issues
// one job per row with a bounded number in flight. Optional macro: CONV_SCHED_PERF_CNT_EN.
`ifndef FRAM_ADDR_WIDTH
`define FRAM_ADDR_WIDTH 16
`endif
`ifndef KRAM_ADDR_WIDTH
`define KRAM_ADDR_WIDTH 16
`endif

module conv_job_scheduler #(
    parameter int FRAM_AW   = `FRAM_ADDR_WIDTH,
    parameter int KRAM_AW   = `KRAM_ADDR_WIDTH,
    parameter int MAX_OUTST = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [15:0]        cfg_out_h,
    input  logic [7:0]         cfg_out_ch,
    input  logic [FRAM_AW-1:0] cfg_fram_base,
    input  logic [FRAM_AW-1:0] cfg_row_stride,
    input  logic [KRAM_AW-1:0] cfg_kram_base,
    input  logic [KRAM_AW-1:0] cfg_k_stride,
    output logic               job_valid,
    input  logic               job_ready,
    output logic [15:0]        job_row,
    output logic [7:0]         job_ch,
    output logic [FRAM_AW-1:0] job_fram_addr,
    output logic [KRAM_AW-1:0] job_kram_addr,
    input  logic               job_done,
    output logic               busy,
    output logic               compute_done,
    input  logic               irq_clr
`ifdef CONV_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]        perf_cycles
`endif
);

    localparam logic [2:0] MAX_O = 3'(MAX_OUTST);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [15:0]        out_h_q;
    logic [7:0]         out_ch_q;
    logic [FRAM_AW-1:0] fram_base_q;
    logic [FRAM_AW-1:0] row_stride_q;
    logic [KRAM_AW-1:0] k_stride_q;
    logic [2:0]         outst_q;

    logic accept, cfg_zero, job_hs, row_last, ch_last, last_job, done_eff;

    assign accept   = cmd_valid && cmd_ready;
    assign cfg_zero = (cfg_out_h == 16'd0) || (cfg_out_ch == 8'd0);
    assign job_hs   = job_valid && job_ready;
    assign row_last = (job_row == out_h_q - 16'd1);
    assign ch_last  = (job_ch == out_ch_q - 8'd1);
    assign last_job = row_last && ch_last;
    // A completion with nothing in flight is stale (e.g. from before a reset).
    assign done_eff = job_done && (outst_q != 3'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        cmd_ready    = 1'b0;
        job_valid    = 1'b0;
        busy         = 1'b0;
        compute_done = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = cfg_zero ? DONE : ISSUE;
            end
            ISSUE: begin
                busy      = 1'b1;
                job_valid = (outst_q != MAX_O);
                if (job_valid && job_ready && last_job) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (outst_q == 3'd0) state_d = DONE;
            end
            DONE: begin
                cmd_ready    = 1'b1;
                compute_done = 1'b1;
                if (cmd_valid)    state_d = cfg_zero ? DONE : ISSUE;
                else if (irq_clr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outst_q <= 3'd0;
        end else begin
            case ({job_hs, done_eff})
                2'b10:   outst_q <= outst_q + 3'd1;
                2'b01:   outst_q <= outst_q - 3'd1;
                default: outst_q <= outst_q;
            endcase
        end
    end

    // Address generation is accumulate-only: row step adds row_stride, channel
    // step reloads the feature base and adds k_stride to the kernel pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_h_q       <= '0;
            out_ch_q      <= '0;
            fram_base_q   <= '0;
            row_stride_q  <= '0;
            k_stride_q    <= '0;
            job_row       <= '0;
            job_ch        <= '0;
            job_fram_addr <= '0;
            job_kram_addr <= '0;
        end else if (accept) begin
            out_h_q       <= cfg_out_h;
            out_ch_q      <= cfg_out_ch;
            fram_base_q   <= cfg_fram_base;
            row_stride_q  <= cfg_row_stride;
            k_stride_q    <= cfg_k_stride;
            job_row       <= '0;
            job_ch        <= '0;
            job_fram_addr <= cfg_fram_base;
            job_kram_addr <= cfg_kram_base;
        end else if (job_hs && !last_job) begin
            if (row_last) begin
                job_row       <= '0;
                job_ch        <= job_ch + 8'd1;
                job_fram_addr <= fram_base_q;
                job_kram_addr <= job_kram_addr + k_stride_q;
            end else begin
                job_row       <= job_row + 16'd1;
                job_fram_addr <= job_fram_addr + row_stride_q;
            end
        end
    end

`ifdef CONV_SCHED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                             perf_cycles <= '0;
        else if (accept)                        perf_cycles <= '0;
        else if (busy && (perf_cycles != '1))   perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule

// File: doc/conv_job_scheduler.md
CONV_JOB_SCHEDULER -- requirements
Module: conv_job_scheduler

Interface
REQ-001 SHALL have parameter FRAM_AW, default `FRAM_ADDR_WIDTH, feature-RAM word-address width.
REQ-002 SHALL have parameter KRAM_AW, default `KRAM_ADDR_WIDTH, kernel-RAM word-address width.
REQ-003 SHALL have parameter MAX_OUTST, default 2, maximum jobs issued but not yet completed (range 1..7).
REQ-004 SHALL use one clock and a synchronous, active-low reset, with ports named as in the rest of the codebase: clk  input  1  rising-edge clock; rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have the following command ports: cmd_valid  input  1  CSR command strobe; cmd_ready  output  1  command accepted.
REQ-006 SHALL have the following configuration inputs: cfg_out_h  input  16  output rows per channel; cfg_out_ch  input  8  output channels.
REQ-007 SHALL have the following base and stride inputs: cfg_fram_base  input  FRAM_AW  first row address; cfg_row_stride  input  FRAM_AW  per-row address step; cfg_kram_base  input  KRAM_AW  first kernel address; cfg_k_stride  input  KRAM_AW  per-channel kernel step.
REQ-008 SHALL have the following job ports: job_valid  output  1; job_ready  input  1; job_row  output  16; job_ch  output  8; job_fram_addr  output  FRAM_AW; job_kram_addr  output  KRAM_AW.
REQ-009 SHALL have job_done  input  1, a one-cycle completion pulse from the engine.
REQ-010 SHALL have the following status ports: busy  output  1; compute_done  output  1  level interrupt; irq_clr  input  1  interrupt clear.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-012 SHALL drive cmd_ready=1 only in IDLE and DONE; a command is accepted on cmd_valid&&cmd_ready.
REQ-013 SHALL latch all cfg_* inputs at command accept; later cfg changes SHALL NOT affect a running command.
REQ-014 SHALL, on accept with cfg_out_h!=0 and cfg_out_ch!=0, enter ISSUE with job_valid=1 on the next cycle, carrying job_row=0, job_ch=0, job_fram_addr=fram_base and job_kram_addr=kram_base.
REQ-015 SHALL, on accept with cfg_out_h==0 or cfg_out_ch==0, go directly to DONE with no jobs issued.
REQ-016 SHALL iterate rows inner and channels outer: after row out_h-1 the row wraps to 0, ch increments, fram_addr resets to base and kram_addr adds k_stride.
REQ-017 SHALL advance fram_addr by row_stride per row using an accumulator, with no multiplier; the sum wraps modulo 2^FRAM_AW.
REQ-018 SHALL hold job_* stable while job_valid=1 and job_ready=0; a job handshakes on job_valid&&job_ready.
REQ-019 SHALL drive job_valid=0 whenever the outstanding count equals MAX_OUTST.
REQ-020 SHALL increment the outstanding count on a job handshake and decrement it on job_done; both in the same cycle leave it unchanged.
REQ-021 SHALL ignore job_done while the outstanding count is 0, with no underflow.
REQ-022 SHALL move from ISSUE to DRAIN after the handshake of the last job (row out_h-1, ch out_ch-1), and drive job_valid=0 in DRAIN.
REQ-023 SHALL move from DRAIN to DONE in the cycle after the outstanding count reaches 0.
REQ-024 SHALL hold compute_done=1 in DONE; irq_clr returns the FSM to IDLE on the next cycle.
REQ-025 SHALL, when a command is accepted in DONE, clear compute_done and start the new command; cmd_valid takes priority over a simultaneous irq_clr.
REQ-026 SHALL drive busy=1 in ISSUE and DRAIN only.

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge, set state=IDLE, cmd_ready=1, job_valid=0, busy=0, compute_done=0, outstanding count=0, job_row=0, job_ch=0 and job_fram_addr=job_kram_addr=0.
REQ-028 SHALL abandon a mid-command reset without generating compute_done; job_done pulses arriving after reset SHALL be ignored.

Configuration
REQ-029 SHALL provide macro CONV_SCHED_PERF_CNT_EN; when defined, it adds output perf_cycles (32 bits) that is cleared at command accept, increments every cycle busy=1, saturates at 0xFFFFFFFF and holds its value in DONE/IDLE until the next accept.
REQ-030 SHALL, without CONV_SCHED_PERF_CNT_EN, omit the perf_cycles port and its counter; all other behaviour is identical.

Verification
REQ-031 SHALL cover: out_h=3, out_ch=2, fram_base=0x100, row_stride=0x20, kram_base=0x40, k_stride=9, job_ready=1, job_done 2 cycles after each handshake -> 6 jobs with fram addresses 0x100, 0x120, 0x140, 0x100, 0x120, 0x140 and kram addresses 0x40, 0x40, 0x40, 0x49, 0x49, 0x49, then compute_done=1.
REQ-032 SHALL cover: MAX_OUTST=2 with job_done withheld -> exactly 2 handshakes occur, then job_valid=0 until a job_done pulse arrives.
REQ-033 SHALL cover: job_ready=0 for 5 cycles mid-stream -> job_* unchanged for all 5 cycles and no job skipped.
REQ-034 SHALL cover: out_ch=0 -> DONE one cycle after accept, zero job_valid cycles, compute_done=1.
REQ-035 SHALL cover: rst_n=0 in the middle of DRAIN -> next cycle state IDLE, compute_done=0, outstanding count=0; a later job_done pulse has no effect.
REQ-036 SHALL cover: cmd_valid and irq_clr in the same DONE cycle -> new command runs, compute_done=0; with CONV_SCHED_PERF_CNT_EN defined, perf_cycles equals the number of cycles busy=1.
